// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and character helpers for the
// HD44780-style hex writer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_8BIT_2LINE = 8'h38;
  localparam logic [7:0] LCD_DISP_ON         = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC       = 8'h06;
  localparam logic [7:0] LCD_CLEAR           = 8'h01;
  localparam logic [7:0] LCD_LINE1           = 8'h80;
  localparam logic [7:0] LCD_LINE2           = 8'hC0;

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_IDLE, ST_ADDR1, ST_CHARS, ST_ADDR2, ST_FINISH
  } lcd_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_SETUP, TX_PULSE, TX_HOLD
  } tx_phase_e;

  function automatic logic [7:0] nibble_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction

  // Character idx (0 = most significant nibble) of a 128-bit word.
  function automatic logic [7:0] char_at(input logic [127:0] v, input logic [4:0] idx);
    logic [6:0] sh;
    sh = {5'd31 - idx, 2'b00};
    return nibble_ascii(4'(v >> sh));
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return LCD_FUNC_8BIT_2LINE;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY_INC;
      default: return LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One LCD bus byte: setup, enable pulse, then hold rs/data until the
// controller's execution time has passed.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned E_PULSE_CYCLES = 12,
  parameter int unsigned CMD_CYCLES     = 2000,
  parameter int unsigned CLEAR_CYCLES   = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs_in,
  input  logic [7:0] byte_in,
  input  logic       is_clear,
  output logic       ack,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] data
);

  localparam int unsigned M1 = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int unsigned M2 = (M1 > E_PULSE_CYCLES) ? M1 : E_PULSE_CYCLES;
  localparam int unsigned M3 = (M2 > SETUP_CYCLES) ? M2 : SETUP_CYCLES;
  localparam int unsigned CW = $clog2(M3 + 1);

  tx_phase_e     r_phase;
  logic [CW-1:0] r_cnt;
  logic          r_clear;
  logic          r_e;
  logic          r_rs;
  logic [7:0]    r_data;

  // The hold is cut two clocks short: ack reaches the sequencer, which
  // registers the next request, so the next byte lands exactly when the
  // full wait has elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= TX_IDLE;
      r_cnt   <= '0;
      r_clear <= 1'b0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      case (r_phase)
        TX_IDLE: begin
          if (req) begin
            r_data  <= byte_in;
            r_rs    <= rs_in;
            r_clear <= is_clear;
            r_cnt   <= CW'(SETUP_CYCLES - 1);
            r_phase <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (r_cnt == '0) begin
            r_e     <= 1'b1;
            r_cnt   <= CW'(E_PULSE_CYCLES - 1);
            r_phase <= TX_PULSE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        TX_PULSE: begin
          if (r_cnt == '0) begin
            r_e     <= 1'b0;
            r_cnt   <= r_clear ? CW'(CLEAR_CYCLES - 2) : CW'(CMD_CYCLES - 2);
            r_phase <= TX_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        TX_HOLD: begin
          if (r_cnt == '0) begin
            r_phase <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_phase <= TX_IDLE;
      endcase
    end
  end

  assign ack    = (r_phase == TX_HOLD) && (r_cnt == '0);
  assign lcd_e  = r_e;
  assign lcd_rs = r_rs;
  assign data   = r_data;

endmodule

// File: rtl/lcd_hex_writer.sv
// Initialises a 16x2 character LCD and writes a 128-bit word to it as
// 32 lowercase hex characters, line 1 then line 2.
module lcd_hex_writer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 1000000,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned E_PULSE_CYCLES = 12,
  parameter int unsigned CMD_CYCLES     = 2000,
  parameter int unsigned CLEAR_CYCLES   = 82000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] value,
  output logic         busy,
  output logic         done,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic [7:0]   data
);

  localparam int unsigned PU_W = $clog2(POWERUP_CYCLES + 1);

  lcd_state_e      r_state;
  logic [PU_W-1:0] r_pu_cnt;
  logic [1:0]      r_step;
  logic [4:0]      r_idx;
  logic [127:0]    r_shadow;
  logic            r_busy;
  logic            r_done;
  logic            r_req;
  logic            r_tx_rs;
  logic [7:0]      r_tx_byte;

  logic            w_ack;
  logic            w_tx_clear;
  logic [4:0]      w_next_idx;
  logic [7:0]      w_next_char;

  assign w_tx_clear  = (r_tx_byte == LCD_CLEAR) && !r_tx_rs;
  assign w_next_char = char_at(r_shadow, w_next_idx);

  // Index of the character that follows the byte now on the bus.
  always_comb begin
    w_next_idx = r_idx + 5'd1;
    case (r_state)
      ST_ADDR1: w_next_idx = 5'd0;
      ST_ADDR2: w_next_idx = 5'd16;
      default:  w_next_idx = r_idx + 5'd1;
    endcase
  end

  // Sequencer: power-up delay, init commands, then address + characters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_POWERUP;
      r_pu_cnt  <= '0;
      r_step    <= 2'd0;
      r_idx     <= 5'd0;
      r_shadow  <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_req     <= 1'b0;
      r_tx_rs   <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_POWERUP: begin
          if (r_pu_cnt == PU_W'(POWERUP_CYCLES - 1)) begin
            r_pu_cnt  <= '0;
            r_step    <= 2'd0;
            r_state   <= ST_INIT;
            r_req     <= 1'b1;
            r_tx_rs   <= 1'b0;
            r_tx_byte <= LCD_FUNC_8BIT_2LINE;
          end else begin
            r_pu_cnt <= r_pu_cnt + 1'b1;
          end
        end
        ST_INIT: begin
          if (w_ack) begin
            if (r_step == 2'd3) begin
              r_state <= ST_IDLE;
            end else begin
              r_step    <= r_step + 2'd1;
              r_req     <= 1'b1;
              r_tx_byte <= init_cmd(r_step + 2'd1);
            end
          end
        end
        ST_IDLE: begin
          // busy drops one clock after entry, so a start coinciding with
          // done (or with the last init byte finishing) is ignored.
          r_busy <= 1'b0;
          if (start && !r_busy) begin
            r_shadow  <= value;
            r_busy    <= 1'b1;
            r_state   <= ST_ADDR1;
            r_req     <= 1'b1;
            r_tx_rs   <= 1'b0;
            r_tx_byte <= LCD_LINE1;
          end
        end
        ST_ADDR1: begin
          if (w_ack) begin
            r_idx     <= 5'd0;
            r_state   <= ST_CHARS;
            r_req     <= 1'b1;
            r_tx_rs   <= 1'b1;
            r_tx_byte <= w_next_char;
          end
        end
        ST_CHARS: begin
          if (w_ack) begin
            if (r_idx == 5'd15) begin
              r_state   <= ST_ADDR2;
              r_req     <= 1'b1;
              r_tx_rs   <= 1'b0;
              r_tx_byte <= LCD_LINE2;
            end else if (r_idx == 5'd31) begin
              r_state <= ST_FINISH;
            end else begin
              r_idx     <= w_next_idx;
              r_req     <= 1'b1;
              r_tx_rs   <= 1'b1;
              r_tx_byte <= w_next_char;
            end
          end
        end
        ST_ADDR2: begin
          if (w_ack) begin
            r_idx     <= 5'd16;
            r_state   <= ST_CHARS;
            r_req     <= 1'b1;
            r_tx_rs   <= 1'b1;
            r_tx_byte <= w_next_char;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_POWERUP;
      endcase
    end
  end

  lcd_byte_tx #(
    .SETUP_CYCLES  (SETUP_CYCLES),
    .E_PULSE_CYCLES(E_PULSE_CYCLES),
    .CMD_CYCLES    (CMD_CYCLES),
    .CLEAR_CYCLES  (CLEAR_CYCLES)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .req     (r_req),
    .rs_in   (r_tx_rs),
    .byte_in (r_tx_byte),
    .is_clear(w_tx_clear),
    .ack     (w_ack),
    .lcd_e   (lcd_e),
    .lcd_rs  (lcd_rs),
    .data    (data)
  );

  assign busy   = r_busy;
  assign done   = r_done;
  assign lcd_rw = 1'b0;

endmodule

// File: doc/lcd_hex_writer.md
Name: lcd_hex_writer

Overview:
- Sequencer that drives a 16x2 HD44780-style character LCD over its 8-bit parallel bus and displays a 128-bit value as 32 lowercase hex ASCII characters: 16 on line 1, 16 on line 2, most significant nibble first.
- Performs the LCD power-up/initialisation sequence itself, then accepts write requests.
- Sits between the AES Decrypt result word and the board LCD pins; it is the only master of the LCD bus.

Parameters:
- POWERUP_CYCLES, 1000000: idle clocks after reset before the first command (20 ms at 50 MHz).
- SETUP_CYCLES, 2: clocks that rs/data are stable before lcd_e rises.
- E_PULSE_CYCLES, 12: clocks lcd_e is held high.
- CMD_CYCLES, 2000: wait clocks after lcd_e falls for any byte except clear.
- CLEAR_CYCLES, 82000: wait clocks after lcd_e falls for the clear command 0x01.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to display value.
- value  in  128  word to display; sampled only when start is accepted.
- busy  out  1  high while powering up, initialising or writing; start is accepted only when busy=0.
- done  out  1  one-cycle pulse when a full 32-character write completes.
- lcd_rw  out  1  LCD read/write select; constant 0 (write only).
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  LCD register select: 0 = command, 1 = data.
- data  out  8  LCD data bus.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-byte):
  - lcd_e=0, lcd_rs=0, lcd_rw=0, data=8'h00, done=0, busy=1.
  - State goes to POWERUP and all counters clear.
- Byte transaction (identical for every byte):
  - Drive rs and data, then hold them for SETUP_CYCLES.
  - Raise lcd_e for E_PULSE_CYCLES, then drop it.
  - Hold rs and data unchanged for WAIT clocks. WAIT = CLEAR_CYCLES for command 0x01, otherwise CMD_CYCLES.
  - Byte time = SETUP_CYCLES + E_PULSE_CYCLES + WAIT. The next byte's rs/data change only after WAIT expires.
- State machine:
  - POWERUP: count POWERUP_CYCLES, then go to INIT.
  - INIT: send commands 0x38, 0x0C, 0x06, 0x01 (rs=0) in that order, then go to IDLE.
  - IDLE: busy=0; lcd_e=0; rs/data keep their last values. On start=1, latch value into a shadow register, set busy=1 on the next clock and go to ADDR1.
  - ADDR1: send command 0x80, then go to CHARS with index 0.
  - CHARS: send a data byte (rs=1) for each index 0..31.
    - Character i = ASCII of nibble value[127-4i -: 4]: 0-9 → 0x30-0x39, a-f → 0x61-0x66.
    - After index 15, go to ADDR2 (send command 0xC0), then resume CHARS at index 16.
    - After index 31's wait expires, go to FINISH.
  - FINISH: done=1 for exactly one clock, then go to IDLE; busy=0 from that IDLE clock.
- Boundary and edge conditions:
  - start while busy=1 (POWERUP, INIT or mid-write) is ignored and not queued.
  - Changes on value after acceptance have no effect on the write in progress.
  - start asserted in the same clock as the done pulse is ignored; it is first accepted the following clock in IDLE.
  - Counters are sized for the largest parameter; no wrap-around within a count.
  - lcd_rw is never driven to 1.

Decomposition:
- Shared package lcd_pkg:
  - Command constants: LCD_FUNC_8BIT_2LINE=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY_INC=8'h06, LCD_CLEAR=8'h01, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - The state enum.
  - A nibble-to-ASCII function (lowercase).
- One sub-module, lcd_byte_tx:
  - Inputs: req, rs_in, byte_in, is_clear.
  - Outputs: ack (one-cycle pulse when WAIT expires), lcd_e, lcd_rs, data.
  - Owns the setup/pulse/wait timer.
- The top-level FSM owns sequencing, the shadow register and the index counter.

Test Plan (sim parameters: POWERUP=20, SETUP=1, E_PULSE=2, CMD=8, CLEAR=16):
- Release rst → lcd_e stays low for 20 clocks; then bytes 0x38, 0x0C, 0x06, 0x01 are sent with rs=0. busy falls exactly 11+11+11+19 clocks after POWERUP ends, and done stays 0.
- start with value=128'h000102030405060708090a0b0c0d0e0f → bus sequence is 0x80, then "0001020304050607" (0x30,0x30,0x30,0x31,...), then 0xC0, then "08090a0b0c0d0e0f". done pulses once after 34×11 clocks, and busy is high throughout.
- value=128'hffeeddccbbaa99887766554433221100 → line 1 bytes start 0x66,0x66,0x65,0x65; line 2 ends 0x30,0x30; every data byte has rs=1.
- start pulsed during INIT and again mid-write, with value changed to all-ones mid-write → no extra transaction occurs and the displayed characters match the originally latched value.
- Assert rst while lcd_e=1 during character 5 → lcd_e=0, data=0x00 and busy=1 immediately (asynchronous); the full POWERUP+INIT sequence then repeats.
- Protocol checker on every byte: rs/data stable ≥1 clock before lcd_e rises, lcd_e high exactly 2 clocks, rs/data unchanged until 8 (or 16 after 0x01) clocks after lcd_e falls, and lcd_rw=0 always.
